register_dump: RTL and testbench
================================

# register_dump

Debug readout engine for the 32-entry register file. On a start pulse it walks every register address through one register-file read port, captures each value, and streams it out as a byte sequence over a valid/ready handshake. Each register produces an address byte followed by the four data bytes, MSB first. It sits beside the CPU datapath and drives a spare read-address port; its byte stream feeds the board's serial/display output path.

## Interface
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width; must be 32 (4 data bytes per register)
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a full dump; sampled only in IDLE
- busy  output  1  high from the cycle after accepted start through the last byte transfer
- done  output  1  one-cycle pulse after the final byte of the final register transfers
- read_register  output  ADDR_WIDTH  address driven to the register file read port
- read_data  input  DATA_WIDTH  combinational read data returned for read_register
- byte_data  output  8  current output byte
- byte_valid  output  1  byte_data is valid
- byte_ready  input  1  downstream accepts byte; a transfer occurs when byte_valid && byte_ready on a rising edge

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - busy=0, byte_valid=0, read_register=0.
  - start=1 -> FETCH with address counter=0.
- FETCH (exactly one cycle):
  - read_register = address counter.
  - read_data is latched into a 32-bit capture register at the rising edge ending the cycle.
  - Byte index is cleared to 0; next state is SEND.
- SEND:
  - byte_valid=1.
  - byte_data by index:
    - index 0: {(8-ADDR_WIDTH)'b0, addr}
    - index 1: capture[31:24]
    - index 2: capture[23:16]
    - index 3: capture[15:8]
    - index 4: capture[7:0]
  - On a transfer with index<4: index increments.
  - On a transfer with index=4 and addr<NUM_REGS-1: addr increments; next state is FETCH.
  - On a transfer with index=4 and addr=NUM_REGS-1: next state is DONE.
- DONE (one cycle): done=1, busy=0, then IDLE.
- Handshake rules:
  - Once byte_valid is asserted, byte_data is held stable and byte_valid stays high until the transfer.
  - byte_valid never depends combinationally on byte_ready.
- start is ignored while in any non-IDLE state, including DONE. No queuing.
- Snapshot semantics:
  - Each register is sampled in its own FETCH cycle.
  - A CPU write landing on the same edge as FETCH is not captured; read_data reflects the pre-write value.
  - Writes to later addresses during a dump appear in the dump.
- read_register holds the last fetched address during SEND; it is only meaningful during FETCH.
- Reset, asynchronous, at any time including mid-dump:
  - State=IDLE, addr=0, index=0, capture=0.
  - busy=0, done=0, byte_valid=0, byte_data=0, read_register=0.
  - A partially sent register is abandoned. No resume.

## Timing
- Start accepted at edge T0:
  - FETCH of reg 0 occurs in cycle T0..T1.
  - busy=1 from T0 onward.
  - First byte_valid is asserted after T1.
- Per register with byte_ready tied high: 1 FETCH + 5 SEND cycles = 6 cycles.
- Full dump with ready tied high: 32×6 = 192 cycles from start acceptance to the last transfer, then done high for exactly 1 cycle.
  - busy falls the same edge done rises.
  - A new start is accepted on the first IDLE cycle after DONE.
- Backpressure: each cycle byte_ready=0 during SEND adds exactly one cycle. No bytes are dropped or duplicated.
- Counters:
  - addr counter is ADDR_WIDTH bits and never wraps past NUM_REGS-1.
  - index counter is 3 bits, range 0..4.

## Test plan
- Preload reg[i]=32'hA5000000+i, tie byte_ready=1, pulse start -> exactly 160 bytes.
  - Register 7 yields 07 A5 00 00 07.
  - done pulses once, 192 cycles after start acceptance.
- Random byte_ready (50%) on the same preload -> identical 160-byte sequence.
  - byte_data is stable whenever byte_valid=1 && byte_ready=0.
- Hold start high continuously -> one dump per start acceptance.
  - Consecutive dumps are separated by the DONE and IDLE cycles.
  - No start is accepted while busy=1.
- CPU writes reg[31]=32'hDEADBEEF while register 5 is being sent -> reg 31 is dumped as 1F DE AD BE EF.
  - A write to reg[3] at the same time leaves the already-dumped value unchanged.
- Assert reset during byte index 2 of register 10:
  - byte_valid=0, busy=0 and read_register=0 immediately, without waiting for a clock edge.
  - After release, a new start restarts from register 0 with address byte 00.
- byte_ready=0 for 20 cycles at index 4 of register 31:
  - done is not asserted until the final transfer.
  - Then done is high for exactly one cycle.

Source files
------------

// File: rtl/register_dump.sv
// Debug readout: walks every register-file address, captures each value and
// streams {addr, data[31:24], data[23:16], data[15:8], data[7:0]} over valid/ready.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start              request a full dump (sampled only while idle)
//   busy, done         dump in progress / one-cycle completion pulse
//   read_register      address to the register-file read port
//   read_data          combinational read data for read_register
//   byte_data/valid    output byte stream, byte_ready from downstream
module register_dump #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_register,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [2:0]              index;
  logic [DATA_WIDTH-1:0]   capture;
  logic [7:0]              next_byte;
  logic                    fire;

  assign fire = byte_valid && byte_ready;

  // Byte to present after the one at the current index is accepted.
  always_comb begin
    next_byte = 8'h00;
    case (index)
      3'd0:    next_byte = capture[31:24];
      3'd1:    next_byte = capture[23:16];
      3'd2:    next_byte = capture[15:8];
      3'd3:    next_byte = capture[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      index         <= 3'd0;
      capture       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      byte_valid    <= 1'b0;
      byte_data     <= 8'h00;
      read_register <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= FETCH;
            addr          <= '0;
            read_register <= '0;
            busy          <= 1'b1;
          end
        end
        FETCH: begin
          capture    <= read_data;
          index      <= 3'd0;
          byte_data  <= 8'(addr);
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (fire) begin
            if (index != 3'd4) begin
              index     <= index + 3'd1;
              byte_data <= next_byte;
            end else begin
              byte_valid <= 1'b0;
              index      <= 3'd0;
              if (addr != LAST_ADDR) begin
                addr          <= addr + 1'b1;
                read_register <= addr + 1'b1;
                state         <= FETCH;
              end else begin
                // busy drops on the same edge done rises
                busy          <= 1'b0;
                done          <= 1'b1;
                addr          <= '0;
                read_register <= '0;
                state         <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump.sv
// Testbench for register_dump: register-file model, byte monitor,
// table-driven per-register checks plus multi-cycle corner sequences.
module tb_register_dump;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  read_register;
  logic [31:0] read_data;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;

  logic [31:0] regs [32];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] q[$];
  int         done_q[$];
  int         rise_q[$];

  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  bit         prev_busy = 1'b0;

  typedef struct {
    int          r;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[6];

  assign read_data = regs[read_register];

  register_dump #(
    .NUM_REGS  (32),
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .read_register(read_register),
    .read_data    (read_data),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge: inputs only change just after rising edges.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {55'd0, byte_valid, byte_data},
            {55'd0, 1'b1, prev_byte});
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_data;
      if (byte_valid && byte_ready) q.push_back(byte_data);
      if (done) done_q.push_back(cyc);
      if (busy && !prev_busy) rise_q.push_back(cyc);
      prev_busy = busy;
    end
  end

  task automatic preload();
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + i;
  endtask

  task automatic clear_logs();
    q.delete();
    done_q.delete();
    rise_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd,
                           input string name);
    int base = done_q.size();
    for (int i = 0; i < limit; i++) begin
      @(posedge clock);
      #1;
      if (rnd) byte_ready = 1'($urandom_range(0, 1));
      if (done_q.size() > base) begin
        byte_ready = 1'b1;
        return;
      end
    end
    byte_ready = 1'b1;
    chk({name, "_timeout"}, 64'(done_q.size()), 64'(base + 1));
  endtask

  task automatic wait_bytes(input int n, input string name);
    for (int i = 0; i < 2000; i++) begin
      if (q.size() >= n) return;
      @(posedge clock);
      #1;
    end
    chk({name, "_timeout"}, 64'(q.size()), 64'(n));
  endtask

  task automatic check_stream(input string name);
    int bad = 0;
    chk({name, "_count"}, 64'(q.size()), 64'd160);
    for (int i = 0; i < q.size(); i++) begin
      logic [7:0] e;
      int r;
      r = i / 5;
      case (i % 5)
        0, 4:    e = 8'(r);
        1:       e = 8'hA5;
        default: e = 8'h00;
      endcase
      if (q[i] !== e) bad++;
    end
    chk({name, "_bytes"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [39:0] reg_bytes(input int r);
    logic [39:0] g = '0;
    for (int k = 0; k < 5; k++) g = {g[31:0], q[r*5+k]};
    return g;
  endfunction

  initial begin
    preload();
    vecs[0] = '{0,  40'h00A5000000};
    vecs[1] = '{1,  40'h01A5000001};
    vecs[2] = '{7,  40'h07A5000007};
    vecs[3] = '{10, 40'h0AA500000A};
    vecs[4] = '{30, 40'h1EA500001E};
    vecs[5] = '{31, 40'h1FA500001F};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(byte_valid), 64'd0);
    chk("rst_byte", 64'(byte_data), 64'd0);
    chk("rst_rreg", 64'(read_register), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Full dump, ready tied high
    clear_logs();
    pulse_start();
    chk("fetch_busy", 64'(busy), 64'd1);
    chk("fetch_valid", 64'(byte_valid), 64'd0);
    chk("fetch_rreg", 64'(read_register), 64'd0);
    wait_done(400, 1'b0, "dumpA");
    repeat (5) @(posedge clock);
    #1;
    check_stream("dumpA");
    if (q.size() == 160)
      for (int i = 0; i < 6; i++)
        chk($sformatf("reg%0d", vecs[i].r),
            64'(reg_bytes(vecs[i].r)), 64'(vecs[i].exp));
    chk("dumpA_dones", 64'(done_q.size()), 64'd1);
    chk("dumpA_rises", 64'(rise_q.size()), 64'd1);
    if (done_q.size() > 0 && rise_q.size() > 0)
      chk("dumpA_cycles", 64'(done_q[0] - rise_q[0]), 64'd192);
    chk("dumpA_idle_busy", 64'(busy), 64'd0);

    // Random backpressure
    clear_logs();
    pulse_start();
    wait_done(3000, 1'b1, "dumpB");
    repeat (3) @(posedge clock);
    #1;
    check_stream("dumpB");
    chk("dumpB_dones", 64'(done_q.size()), 64'd1);

    // Start held high: back-to-back dumps
    clear_logs();
    @(posedge clock);
    #1 start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      #1;
      if (done_q.size() >= 2) break;
    end
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("hold_dones", 64'(done_q.size()), 64'd2);
    chk("hold_rises", 64'(rise_q.size()), 64'd2);
    chk("hold_bytes", 64'(q.size()), 64'd320);
    if (done_q.size() >= 1 && rise_q.size() >= 2)
      chk("hold_gap", 64'(rise_q[1] - done_q[0]), 64'd2);

    // CPU writes while register 5 is being sent
    clear_logs();
    pulse_start();
    wait_bytes(25, "write");
    regs[31] = 32'hDEAD_BEEF;
    regs[3]  = 32'h1234_5678;
    wait_done(400, 1'b0, "write");
    chk("write_count", 64'(q.size()), 64'd160);
    if (q.size() == 160) begin
      chk("write_reg31", 64'(reg_bytes(31)), 64'h1FDEADBEEF);
      chk("write_reg3", 64'(reg_bytes(3)), 64'h03A5000003);
    end
    preload();

    // Reset during byte index 2 of register 10
    clear_logs();
    pulse_start();
    wait_bytes(52, "rstmid");
    byte_ready = 1'b0;
    chk("rstmid_pre_valid", 64'(byte_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_valid", 64'(byte_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_rreg", 64'(read_register), 64'd0);
    byte_ready = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    clear_logs();
    pulse_start();
    wait_done(400, 1'b0, "rstmid");
    if (q.size() > 0) chk("rstmid_first", 64'(q[0]), 64'd0);
    check_stream("rstmid");

    // 20 stalled cycles on the final byte
    clear_logs();
    pulse_start();
    wait_bytes(159, "stall");
    byte_ready = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("stall_no_done", 64'(done_q.size()), 64'd0);
    chk("stall_byte", {55'd0, byte_valid, byte_data}, 64'h11F);
    byte_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("stall_done_hi", 64'(done), 64'd1);
    @(posedge clock);
    #1;
    chk("stall_done_lo", 64'(done), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("stall_dones", 64'(done_q.size()), 64'd1);
    check_stream("stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
